// File: rtl/izh_pkg.sv
// Shared constants, parameter record and saturation helpers for the Izhikevich neuron array.
package izh_pkg;

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned FRAC     = 8;
  localparam int unsigned DT_SHIFT = 2;
  localparam int unsigned WIDE_W   = 2 * DATA_W + 16;

  localparam int K_SQ    = 41;
  localparam int K_LIN   = 5;
  localparam int K_CONST = 140;

  localparam logic signed [DATA_W-1:0] V_RESET = DATA_W'(-65 <<< FRAC);
  localparam logic signed [DATA_W-1:0] V_PEAK  = DATA_W'(30 <<< FRAC);

  localparam logic signed [WIDE_W-1:0] SAT_MAX = WIDE_W'((1 <<< (DATA_W - 1)) - 1);
  localparam logic signed [WIDE_W-1:0] SAT_MIN = -SAT_MAX - WIDE_W'(1);

  // Field order matches the serial frame order a, b, c, d (a is most significant).
  typedef struct packed {
    logic signed [DATA_W-1:0] a;
    logic signed [DATA_W-1:0] b;
    logic signed [DATA_W-1:0] c;
    logic signed [DATA_W-1:0] d;
  } izh_param_t;

  function automatic logic signed [DATA_W-1:0] sat_wide(input logic signed [WIDE_W-1:0] x);
    if (x > SAT_MAX) begin
      return DATA_W'(SAT_MAX);
    end else if (x < SAT_MIN) begin
      return DATA_W'(SAT_MIN);
    end
    return DATA_W'(x);
  endfunction

  function automatic logic signed [DATA_W-1:0] sat_add(input logic signed [DATA_W-1:0] x,
                                                        input logic signed [DATA_W-1:0] y);
    logic signed [WIDE_W-1:0] sum;
    sum = WIDE_W'(x) + WIDE_W'(y);
    return sat_wide(sum);
  endfunction

endpackage

// File: rtl/izh_neuron_array_update_dp.sv
// Combinational single-step Izhikevich update for one neuron (Euler step of 2^-DT_SHIFT).
module izh_update_dp #(
  parameter int unsigned FRAC     = izh_pkg::FRAC,
  parameter int unsigned DT_SHIFT = izh_pkg::DT_SHIFT
) (
  input  logic signed [izh_pkg::DATA_W-1:0] v,
  input  logic signed [izh_pkg::DATA_W-1:0] u,
  input  izh_pkg::izh_param_t               prm,
  input  logic        [7:0]                 stim,
  output logic signed [izh_pkg::DATA_W-1:0] v_next_c,
  output logic signed [izh_pkg::DATA_W-1:0] u_next_c,
  output logic                              spike_c
);
  import izh_pkg::*;

  localparam logic signed [DATA_W-1:0] PEAK = DATA_W'(30 <<< FRAC);

  logic signed [WIDE_W-1:0] v_w, u_w, a_w, b_w, i_w;
  logic signed [WIDE_W-1:0] dv_w, v1_w, bv_w, du_w, u1_w;
  logic signed [DATA_W-1:0] v1, u1;

  // Everything is widened first so products and shifts are exact before saturation.
  always_comb begin
    v_w  = WIDE_W'(v);
    u_w  = WIDE_W'(u);
    a_w  = WIDE_W'(prm.a);
    b_w  = WIDE_W'(prm.b);
    i_w  = WIDE_W'(stim) <<< FRAC;
    dv_w = ((WIDE_W'(K_SQ) * v_w * v_w) >>> (FRAC + 10)) + WIDE_W'(K_LIN) * v_w
           + (WIDE_W'(K_CONST) <<< FRAC) - u_w + i_w;
    v1_w = v_w + (dv_w >>> DT_SHIFT);
    bv_w = (b_w * v_w) >>> FRAC;
    du_w = (a_w * (bv_w - u_w)) >>> FRAC;
    u1_w = u_w + (du_w >>> DT_SHIFT);
    v1   = sat_wide(v1_w);
    u1   = sat_wide(u1_w);
    spike_c  = (v1 >= PEAK);
    v_next_c = spike_c ? prm.c : v1;
    u_next_c = spike_c ? sat_add(u1, prm.d) : u1;
  end

endmodule

// File: rtl/izh_neuron_array.sv
// N time-multiplexed Izhikevich neurons sharing one update datapath, with an addressed
// serial parameter loader and a tick-driven sweep FSM.
module izh_neuron_array #(
  parameter int unsigned N_NEURONS = 8,
  parameter int unsigned ADDR_W    = 6,
  parameter int unsigned DATA_W    = izh_pkg::DATA_W,
  parameter int unsigned FRAC      = izh_pkg::FRAC,
  parameter int unsigned DT_SHIFT  = izh_pkg::DT_SHIFT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     tick,
  input  logic [8*N_NEURONS-1:0]   stimulus_in,
  input  logic                     load_mode,
  input  logic                     serial_data,
  input  logic [ADDR_W-1:0]        mon_sel,
  output logic [7:0]               membrane_out,
  output logic [N_NEURONS-1:0]     spike_out,
  output logic                     spike_valid,
  output logic                     busy,
  output logic                     overrun,
  output logic                     params_ready
);
  import izh_pkg::*;

  localparam int unsigned IDX_W   = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;
  localparam int unsigned FRAME_W = ADDR_W + 4 * DATA_W;
  localparam int unsigned CNT_W   = $clog2(FRAME_W);
  localparam logic signed [DATA_W-1:0] V_RESET_L = DATA_W'(-65 <<< FRAC);

  typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DONE} state_t;

  state_t                   state_q, state_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [N_NEURONS-1:0]     acc_q, acc_d, spike_q, spike_d, loaded_q, loaded_d;
  logic                     valid_q, valid_d, busy_q, busy_d, overrun_q, overrun_d;
  logic                     ready_q, ready_d;
  logic [7:0]               membrane_q, membrane_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [FRAME_W-2:0]       shreg_q, shreg_d;
  logic [FRAME_W-1:0]       frame;
  logic [ADDR_W-1:0]        frame_addr;
  izh_param_t               params_q [N_NEURONS];
  izh_param_t               params_d [N_NEURONS];
  logic signed [DATA_W-1:0] v_q [N_NEURONS];
  logic signed [DATA_W-1:0] v_d [N_NEURONS];
  logic signed [DATA_W-1:0] u_q [N_NEURONS];
  logic signed [DATA_W-1:0] u_d [N_NEURONS];
  logic signed [DATA_W-1:0] v_next_c, u_next_c;
  logic                     spike_c;

  izh_update_dp #(.FRAC(FRAC), .DT_SHIFT(DT_SHIFT)) u_dp (
    .v        (v_q[idx_q]),
    .u        (u_q[idx_q]),
    .prm      (params_q[idx_q]),
    .stim     (stimulus_in[{idx_q, 3'b000} +: 8]),
    .v_next_c (v_next_c),
    .u_next_c (u_next_c),
    .spike_c  (spike_c)
  );

  assign frame      = {shreg_q, serial_data};
  assign frame_addr = frame[FRAME_W-1 -: ADDR_W];

  // Sweep FSM, neuron state write-back and the serial loader.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    acc_d      = acc_q;
    spike_d    = spike_q;
    valid_d    = 1'b0;
    overrun_d  = overrun_q | (tick & busy_q);
    v_d        = v_q;
    u_d        = u_q;
    cnt_d      = cnt_q;
    shreg_d    = shreg_q;
    loaded_d   = loaded_q;
    params_d   = params_q;
    ready_d    = &loaded_q;
    membrane_d = '0;

    case (state_q)
      S_IDLE: begin
        if (tick && enable && ready_q) begin
          state_d = S_SWEEP;
          idx_d   = '0;
          acc_d   = '0;
        end
      end
      S_SWEEP: begin
        if (enable) begin
          v_d[idx_q]   = v_next_c;
          u_d[idx_q]   = u_next_c;
          acc_d[idx_q] = spike_c;
          if (idx_q == IDX_W'(N_NEURONS - 1)) begin
            state_d = S_DONE;
            spike_d = acc_d;
            valid_d = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      S_DONE: begin
        if (enable) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_SWEEP);

    // Out-of-range addresses complete the frame but write nothing.
    if (enable) begin
      if (!load_mode) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_W'(FRAME_W - 1)) begin
        cnt_d = '0;
        if ({1'b0, frame_addr} < (ADDR_W + 1)'(N_NEURONS)) begin
          params_d[IDX_W'(frame_addr)] = izh_param_t'(frame[4*DATA_W-1:0]);
          loaded_d[IDX_W'(frame_addr)] = 1'b1;
        end
      end else begin
        cnt_d   = cnt_q + CNT_W'(1);
        shreg_d = frame[FRAME_W-2:0];
      end
    end

    if ({1'b0, mon_sel} < (ADDR_W + 1)'(N_NEURONS)) begin
      membrane_d = v_q[IDX_W'(mon_sel)][FRAC+7:FRAC];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      acc_q      <= '0;
      spike_q    <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
      ready_q    <= 1'b0;
      membrane_q <= '0;
      cnt_q      <= '0;
      shreg_q    <= '0;
      loaded_q   <= '0;
      params_q   <= '{default: '0};
      v_q        <= '{default: V_RESET_L};
      u_q        <= '{default: '0};
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      acc_q      <= acc_d;
      spike_q    <= spike_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      overrun_q  <= overrun_d;
      ready_q    <= ready_d;
      membrane_q <= membrane_d;
      cnt_q      <= cnt_d;
      shreg_q    <= shreg_d;
      loaded_q   <= loaded_d;
      params_q   <= params_d;
      v_q        <= v_d;
      u_q        <= u_d;
    end
  end

  assign membrane_out = membrane_q;
  assign spike_out    = spike_q;
  assign spike_valid  = valid_q;
  assign busy         = busy_q;
  assign overrun      = overrun_q;
  assign params_ready = ready_q;

endmodule

// File: tb/tb_izh_neuron_array.sv
// Directed bench for izh_neuron_array: loader, sweep timing table, spike behaviour, reset abort.
module tb_izh_neuron_array;

  localparam int unsigned N  = 8;
  localparam int unsigned AW = 6;
  localparam int unsigned FW = AW + 64;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic          tick = 1'b0;
  logic [8*N-1:0] stimulus_in = '0;
  logic          load_mode = 1'b0;
  logic          serial_data = 1'b0;
  logic [AW-1:0] mon_sel = '0;
  logic [7:0]    membrane_out;
  logic [N-1:0]  spike_out;
  logic          spike_valid, busy, overrun, params_ready;

  always #5 clk = ~clk;

  izh_neuron_array dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .tick         (tick),
    .stimulus_in  (stimulus_in),
    .load_mode    (load_mode),
    .serial_data  (serial_data),
    .mon_sel      (mon_sel),
    .membrane_out (membrane_out),
    .spike_out    (spike_out),
    .spike_valid  (spike_valid),
    .busy         (busy),
    .overrun      (overrun),
    .params_ready (params_ready)
  );

  int checks = 0;
  int errors = 0;

  longint mv [N];
  longint mu [N];
  longint pa [N];
  longint pb [N];
  longint pc [N];
  longint pd [N];
  int     stim_m [N];

  typedef struct {
    logic tick;
    logic en;
    logic busy;
    logic valid;
    logic ovr;
  } vec_t;
  vec_t tv [22];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic longint sat16(input longint x);
    if (x > 32767) return 32767;
    if (x < -32768) return -32768;
    return x;
  endfunction

  task automatic set_params(input int k, input logic [63:0] p);
    pa[k] = longint'($signed(p[63:48]));
    pb[k] = longint'($signed(p[47:32]));
    pc[k] = longint'($signed(p[31:16]));
    pd[k] = longint'($signed(p[15:0]));
  endtask

  // Reference model of one full sweep over all neurons.
  task automatic model_sweep(output logic [N-1:0] spk);
    longint v, u, dv, v1, bv, du, u1;
    spk = '0;
    for (int k = 0; k < N; k++) begin
      v  = mv[k];
      u  = mu[k];
      dv = ((41 * v * v) >>> 18) + 5 * v + 140 * 256 - u + longint'(stim_m[k]) * 256;
      v1 = sat16(v + (dv >>> 2));
      bv = (pb[k] * v) >>> 8;
      du = (pa[k] * (bv - u)) >>> 8;
      u1 = sat16(u + (du >>> 2));
      if (v1 >= 30 * 256) begin
        mv[k]  = pc[k];
        mu[k]  = sat16(u1 + pd[k]);
        spk[k] = 1'b1;
      end else begin
        mv[k] = v1;
        mu[k] = u1;
      end
    end
  endtask

  task automatic check_state();
    for (int k = 0; k < N; k++) begin
      chk($sformatf("v%0d", k), longint'(dut.v_q[k]), mv[k]);
      chk($sformatf("u%0d", k), longint'(dut.u_q[k]), mu[k]);
    end
  endtask

  task automatic send_frame(input logic [AW-1:0] addr, input logic [63:0] prm, input int nbits);
    logic [FW-1:0] f;
    f = {addr, prm};
    for (int i = 0; i < nbits; i++) begin
      load_mode   = 1'b1;
      serial_data = f[FW-1-i];
      step();
    end
    load_mode   = 1'b0;
    serial_data = 1'b0;
  endtask

  task automatic run_vec(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      tick   = tv[i].tick;
      enable = tv[i].en;
      step();
      chk($sformatf("row%0d_busy", i), longint'(busy), longint'(tv[i].busy));
      chk($sformatf("row%0d_valid", i), longint'(spike_valid), longint'(tv[i].valid));
      chk($sformatf("row%0d_overrun", i), longint'(overrun), longint'(tv[i].ovr));
    end
    tick   = 1'b0;
    enable = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0]  p_std, p3;
    logic [63:0]  p3_act;
    logic [N-1:0] spk;
    logic         got_spike, timed_out, seen_valid;
    int           waited;

    p_std = {16'h0005, 16'h0033, 16'hBF00, 16'h0800};
    p3    = {16'h000A, 16'h0033, 16'hC100, 16'h0400};
    for (int k = 0; k < N; k++) begin
      mv[k] = -16640;
      mu[k] = 0;
      stim_m[k] = 0;
      set_params(k, p_std);
    end
    set_params(3, p3);

    // Sweep timing: plain sweep (rows 0..9), then overrun tick and two enable-low cycles.
    for (int i = 0; i < 22; i++) begin
      tv[i] = '{tick: 1'b0, en: 1'b1, busy: 1'b0, valid: 1'b0, ovr: 1'b0};
    end
    tv[0].tick = 1'b1;
    for (int i = 0; i < 8; i++) tv[i].busy = 1'b1;
    tv[8].valid = 1'b1;
    tv[10].tick = 1'b1;
    tv[13].tick = 1'b1;
    tv[14].en   = 1'b0;
    tv[15].en   = 1'b0;
    for (int i = 10; i < 20; i++) tv[i].busy = 1'b1;
    tv[20].valid = 1'b1;
    for (int i = 13; i < 22; i++) tv[i].ovr = 1'b1;

    // Reset
    enable = 1'b1;
    repeat (5) step();
    chk("rst_membrane", longint'(membrane_out), 0);
    chk("rst_spike_out", longint'(spike_out), 0);
    chk("rst_valid", longint'(spike_valid), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_overrun", longint'(overrun), 0);
    chk("rst_ready", longint'(params_ready), 0);
    reset = 1'b0;
    step();
    chk("mon0_after_reset", longint'(membrane_out), 8'hBF);
    tick = 1'b1;
    step();
    tick = 1'b0;
    chk("tick_unready_busy", longint'(busy), 0);
    step();
    chk("tick_unready_valid", longint'(spike_valid), 0);
    chk("tick_unready_overrun", longint'(overrun), 0);

    // Loader
    for (int k = 0; k < 7; k++) begin
      send_frame(AW'(k), p_std, FW);
      step();
    end
    chk("ready_after_7", longint'(params_ready), 0);
    send_frame(AW'(9), p_std, FW);
    step();
    chk("mask_after_addr9", longint'(dut.loaded_q), 8'h7F);
    send_frame(AW'(7), p_std, 20);
    step();
    chk("mask_after_partial", longint'(dut.loaded_q), 8'h7F);
    send_frame(AW'(3), p3, FW);
    step();
    p3_act = dut.params_q[3];
    chk("params3_hi", longint'(p3_act[63:32]), longint'(p3[63:32]));
    chk("params3_lo", longint'(p3_act[31:0]), longint'(p3[31:0]));
    chk("mask_after_n3", longint'(dut.loaded_q), 8'h7F);
    send_frame(AW'(7), p_std, FW);
    chk("ready_same_cycle", longint'(params_ready), 0);
    step();
    chk("ready_next_cycle", longint'(params_ready), 1);

    // Sweep with zero stimulus
    run_vec(0, 10);
    model_sweep(spk);
    chk("sweepA_spike_out", longint'(spike_out), longint'(spk));
    check_state();
    chk("sweepA_mon0", longint'(membrane_out), (mv[0] >>> 8) & 255);

    // Overrun and enable stall
    run_vec(10, 22);
    model_sweep(spk);
    chk("sweepB_spike_out", longint'(spike_out), longint'(spk));
    check_state();

    // Spiking neuron 5
    stim_m[5] = 255;
    stimulus_in[5*8 +: 8] = 8'd255;
    mon_sel = AW'(5);
    got_spike = 1'b0;
    for (int s = 0; s < 10 && !got_spike; s++) begin
      tick = 1'b1;
      step();
      tick = 1'b0;
      timed_out = 1'b1;
      for (waited = 0; waited < 30; waited++) begin
        if (spike_valid) begin
          timed_out = 1'b0;
          break;
        end
        step();
      end
      if (timed_out) begin
        chk("sweep_timeout", 0, 1);
        break;
      end
      model_sweep(spk);
      chk($sformatf("spk_sweep%0d", s), longint'(spike_out), longint'(spk));
      chk($sformatf("mon5_sweep%0d", s), longint'(membrane_out), (mv[5] >>> 8) & 255);
      check_state();
      if (spike_out[5]) got_spike = 1'b1;
      step();
    end
    chk("neuron5_spiked", longint'(got_spike), 1);
    chk("v5_reset_value", longint'(dut.v_q[5]), -16640);
    chk("overrun_sticky", longint'(overrun), 1);

    mon_sel = AW'(9);
    step();
    step();
    chk("mon_out_of_range", longint'(membrane_out), 0);

    // Reset mid-sweep aborts with no spike_valid
    mon_sel = '0;
    tick = 1'b1;
    step();
    tick = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_busy", longint'(busy), 0);
    chk("abort_overrun", longint'(overrun), 0);
    chk("abort_spike_out", longint'(spike_out), 0);
    chk("abort_ready", longint'(params_ready), 0);
    chk("abort_v5", longint'(dut.v_q[5]), -16640);
    seen_valid = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (spike_valid) seen_valid = 1'b1;
    end
    chk("abort_no_valid", longint'(seen_valid), 0);
    chk("abort_mon0", longint'(membrane_out), 8'hBF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
